// File: rtl/quota_table_sched.sv
// Per-id byte quota table: packets charge their length against a RAM entry, the host refills
// entries. One FSM serialises every table access, so there are no read-after-write hazards.
module quota_table_sched #(
  parameter int unsigned NUM_ID     = 150,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        asclk,
  input  logic        aresetn,
  input  logic        pkt_vld,
  output logic        pkt_rdy,
  input  logic [13:0] pkt_id,
  input  logic [15:0] pkt_len,
  input  logic        pkt_cnt_en,
  input  logic        cfg_vld,
  output logic        cfg_rdy,
  input  logic [13:0] cfg_id,
  input  logic [48:0] cfg_wdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [13:0] mem_addr,
  output logic [48:0] mem_wdata,
  input  logic [48:0] mem_rdata,
  output logic        res_vld,
  output logic [13:0] res_id,
  output logic [2:0]  res_policy,
  output logic        res_err,
  output logic        init_done,
  output logic [31:0] exceed_cnt
);

  localparam int unsigned StarveW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_MAX);
  localparam logic [14:0] NumId = 15'(NUM_ID);
  localparam logic [13:0] LastId = 14'(NUM_ID - 1);

  typedef enum logic [2:0] {StInit, StIdle, StPktRd, StPktWr, StCfgWr} state_e;

  state_e              state_q, state_d;
  logic [13:0]         init_addr_q, init_addr_d;
  logic                init_done_q, init_done_d;
  logic [StarveW-1:0]  starve_cnt_q, starve_cnt_d;
  logic [31:0]         exceed_cnt_q, exceed_cnt_d;
  logic [13:0]         id_q, id_d;
  logic [15:0]         len_q, len_d;
  logic                rd_ok_q, rd_ok_d;
  logic                id_bad_q, id_bad_d;
  logic [13:0]         cfg_id_q, cfg_id_d;
  logic [48:0]         cfg_wdata_q, cfg_wdata_d;
  logic                cfg_ok_q, cfg_ok_d;
  logic                res_vld_q, res_vld_d;
  logic [13:0]         res_id_q, res_id_d;
  logic [2:0]          res_policy_q, res_policy_d;
  logic                res_err_q, res_err_d;
  logic                mem_en_c, mem_we_c;
  logic [47:0]         rem, len_ext;

  always_comb begin
    state_d      = state_q;
    init_addr_d  = init_addr_q;
    init_done_d  = init_done_q;
    starve_cnt_d = starve_cnt_q;
    exceed_cnt_d = exceed_cnt_q;
    id_d         = id_q;
    len_d        = len_q;
    rd_ok_d      = rd_ok_q;
    id_bad_d     = id_bad_q;
    cfg_id_d     = cfg_id_q;
    cfg_wdata_d  = cfg_wdata_q;
    cfg_ok_d     = cfg_ok_q;
    res_vld_d    = 1'b0;
    res_id_d     = res_id_q;
    res_policy_d = res_policy_q;
    res_err_d    = res_err_q;
    pkt_rdy      = 1'b0;
    cfg_rdy      = 1'b0;
    mem_en_c     = 1'b0;
    mem_we_c     = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    rem          = mem_rdata[47:0];
    len_ext      = {32'd0, len_q};
    unique case (state_q)
      StInit: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr    = init_addr_q;
        init_addr_d = init_addr_q + 14'd1;
        if (init_addr_q == LastId) begin
          state_d     = StIdle;
          init_done_d = 1'b1;
        end
      end
      StIdle: begin
        // Config wins when packets are idle or have starved it for STARVE_MAX grants.
        cfg_rdy = cfg_vld && (!pkt_vld || starve_cnt_q == StarveMax);
        pkt_rdy = !cfg_rdy;
        if (cfg_rdy) begin
          starve_cnt_d = '0;
          cfg_id_d     = cfg_id;
          cfg_wdata_d  = cfg_wdata;
          cfg_ok_d     = {1'b0, cfg_id} < NumId;
          state_d      = StCfgWr;
        end else if (pkt_vld) begin
          if (cfg_vld && starve_cnt_q != StarveMax) starve_cnt_d = starve_cnt_q + 1'b1;
          id_d     = pkt_id;
          len_d    = pkt_len;
          id_bad_d = !({1'b0, pkt_id} < NumId);
          rd_ok_d  = pkt_cnt_en && ({1'b0, pkt_id} < NumId);
          state_d  = StPktRd;
        end
      end
      StPktRd: begin
        mem_en_c = rd_ok_q;
        mem_addr = id_q;
        state_d  = StPktWr;
      end
      StPktWr: begin
        res_vld_d    = 1'b1;
        res_id_d     = id_q;
        res_err_d    = id_bad_q;
        res_policy_d = 3'd4;
        if (rd_ok_q) begin
          mem_en_c = 1'b1;
          mem_we_c = 1'b1;
          mem_addr = id_q;
          if (rem < len_ext) begin
            mem_wdata    = {mem_rdata[48], 48'd0};
            res_policy_d = mem_rdata[48] ? 3'd2 : 3'd1;
            exceed_cnt_d = exceed_cnt_q + 32'd1;
          end else begin
            mem_wdata = {mem_rdata[48], rem - len_ext};
          end
        end
        state_d = StIdle;
      end
      StCfgWr: begin
        mem_en_c  = cfg_ok_q;
        mem_we_c  = cfg_ok_q;
        mem_addr  = cfg_id_q;
        mem_wdata = cfg_wdata_q;
        state_d   = StIdle;
      end
      default: state_d = StInit;
    endcase
  end

  // Reset sits in INIT, whose writes must stay off the RAM until reset is released.
  assign mem_en     = mem_en_c & aresetn;
  assign mem_we     = mem_we_c & aresetn;
  assign res_vld    = res_vld_q;
  assign res_id     = res_id_q;
  assign res_policy = res_policy_q;
  assign res_err    = res_err_q;
  assign init_done  = init_done_q;
  assign exceed_cnt = exceed_cnt_q;

  always_ff @(posedge asclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StInit;
      init_addr_q  <= '0;
      init_done_q  <= 1'b0;
      starve_cnt_q <= '0;
      exceed_cnt_q <= '0;
      id_q         <= '0;
      len_q        <= '0;
      rd_ok_q      <= 1'b0;
      id_bad_q     <= 1'b0;
      cfg_id_q     <= '0;
      cfg_wdata_q  <= '0;
      cfg_ok_q     <= 1'b0;
      res_vld_q    <= 1'b0;
      res_id_q     <= '0;
      res_policy_q <= '0;
      res_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_addr_q  <= init_addr_d;
      init_done_q  <= init_done_d;
      starve_cnt_q <= starve_cnt_d;
      exceed_cnt_q <= exceed_cnt_d;
      id_q         <= id_d;
      len_q        <= len_d;
      rd_ok_q      <= rd_ok_d;
      id_bad_q     <= id_bad_d;
      cfg_id_q     <= cfg_id_d;
      cfg_wdata_q  <= cfg_wdata_d;
      cfg_ok_q     <= cfg_ok_d;
      res_vld_q    <= res_vld_d;
      res_id_q     <= res_id_d;
      res_policy_q <= res_policy_d;
      res_err_q    <= res_err_d;
    end
  end

endmodule

// File: tb/tb_quota_table_sched.sv
// Directed bench for quota_table_sched: init sweep, charging, refills, arbitration, reset abort.
module tb_quota_table_sched;
  localparam int unsigned NumId = 150;

  logic        asclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        pkt_vld = 1'b0, pkt_cnt_en = 1'b0, cfg_vld = 1'b0;
  logic [13:0] pkt_id = '0, cfg_id = '0;
  logic [15:0] pkt_len = '0;
  logic [48:0] cfg_wdata = '0;
  logic [48:0] mem_rdata = '0;
  logic        pkt_rdy, cfg_rdy, mem_en, mem_we, res_vld, res_err, init_done;
  logic [13:0] mem_addr, res_id;
  logic [48:0] mem_wdata;
  logic [2:0]  res_policy;
  logic [31:0] exceed_cnt;
  logic [48:0] ram [NumId];

  int n_cmp = 0;
  int n_bad = 0;

  quota_table_sched #(.NUM_ID(NumId), .STARVE_MAX(4)) dut (
    .asclk(asclk), .aresetn(aresetn),
    .pkt_vld(pkt_vld), .pkt_rdy(pkt_rdy), .pkt_id(pkt_id), .pkt_len(pkt_len),
    .pkt_cnt_en(pkt_cnt_en),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_id(cfg_id), .cfg_wdata(cfg_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .res_vld(res_vld), .res_id(res_id), .res_policy(res_policy), .res_err(res_err),
    .init_done(init_done), .exceed_cnt(exceed_cnt)
  );

  always #5 asclk = ~asclk;

  // Single-port RAM, one-cycle read latency.
  always @(posedge asclk) begin
    if (mem_en && {18'd0, mem_addr} < NumId) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at negedge+1 with the DUT in IDLE.
  task automatic pkt_op(input logic [13:0] id, input logic [15:0] len, input logic en,
                        input logic exp_rd, input logic [48:0] exp_wd,
                        input logic [2:0] exp_pol, input logic exp_err);
    pkt_vld = 1'b1; pkt_id = id; pkt_len = len; pkt_cnt_en = en;
    #1;
    chk("pkt_rdy", 64'(pkt_rdy), 64'(1'b1));
    @(negedge asclk); pkt_vld = 1'b0; #1;
    chk("rd_en", 64'(mem_en), 64'(exp_rd));
    if (exp_rd) begin
      chk("rd_we", 64'(mem_we), 64'(1'b0));
      chk("rd_addr", 64'(mem_addr), 64'(id));
    end
    chk("res_early", 64'(res_vld), 64'(1'b0));
    @(negedge asclk); #1;
    chk("wr_en", 64'(mem_en), 64'(exp_rd));
    if (exp_rd) begin
      chk("wr_we", 64'(mem_we), 64'(1'b1));
      chk("wr_data", 64'(mem_wdata), 64'(exp_wd));
    end
    @(negedge asclk); #1;
    chk("res_vld", 64'(res_vld), 64'(1'b1));
    chk("res_id", 64'(res_id), 64'(id));
    chk("res_policy", 64'(res_policy), 64'(exp_pol));
    chk("res_err", 64'(res_err), 64'(exp_err));
    chk("idle_rdy", 64'(pkt_rdy), 64'(1'b1));
    @(negedge asclk); #1;
    chk("res_pulse", 64'(res_vld), 64'(1'b0));
  endtask

  task automatic cfg_op(input logic [13:0] id, input logic [48:0] wd, input logic exp_wr);
    cfg_vld = 1'b1; cfg_id = id; cfg_wdata = wd;
    #1;
    chk("cfg_rdy", 64'(cfg_rdy), 64'(1'b1));
    chk("cfg_pkt_rdy", 64'(pkt_rdy), 64'(1'b0));
    @(negedge asclk); cfg_vld = 1'b0; #1;
    chk("cfg_en", 64'(mem_en), 64'(exp_wr));
    if (exp_wr) begin
      chk("cfg_addr", 64'(mem_addr), 64'(id));
      chk("cfg_data", 64'(mem_wdata), 64'(wd));
    end
    @(negedge asclk); #1;
    chk("cfg_back_idle", 64'(pkt_rdy), 64'(1'b1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int good;
    int grants;
    int nres;
    logic seen;

    // Reset state, with both requests asserted to prove nothing is granted.
    pkt_vld = 1'b1; cfg_vld = 1'b1;
    #2;
    chk("rst_init_done", 64'(init_done), 64'(1'b0));
    chk("rst_mem_en", 64'(mem_en), 64'(1'b0));
    chk("rst_mem_we", 64'(mem_we), 64'(1'b0));
    chk("rst_pkt_rdy", 64'(pkt_rdy), 64'(1'b0));
    chk("rst_cfg_rdy", 64'(cfg_rdy), 64'(1'b0));
    chk("rst_res_vld", 64'(res_vld), 64'(1'b0));
    chk("rst_res_policy", 64'(res_policy), 64'(3'd0));
    chk("rst_res_err", 64'(res_err), 64'(1'b0));
    chk("rst_exceed", 64'(exceed_cnt), 64'(32'd0));

    @(negedge asclk); aresetn = 1'b1; #1;
    good = 0;
    for (int k = 0; k < int'(NumId); k++) begin
      if (mem_en && mem_we && {18'd0, mem_addr} == k && mem_wdata == '0 && !pkt_rdy && !cfg_rdy
          && !init_done) good++;
      @(negedge asclk); #1;
    end
    chk("init_writes", 64'(good), 64'(NumId));
    pkt_vld = 1'b0; cfg_vld = 1'b0; #1;
    chk("init_done", 64'(init_done), 64'(1'b1));
    chk("idle_mem_en", 64'(mem_en), 64'(1'b0));
    chk("idle_pkt_rdy", 64'(pkt_rdy), 64'(1'b1));

    // Refill id 5 then charge it twice: 1000-600=400, then 400<600 exceeds with flag=host.
    cfg_op(14'd5, {1'b1, 48'd1000}, 1'b1);
    pkt_op(14'd5, 16'd600, 1'b1, 1'b1, {1'b1, 48'd400}, 3'd4, 1'b0);
    chk("ram5_400", 64'(ram[5]), 64'({1'b1, 48'd400}));
    pkt_op(14'd5, 16'd600, 1'b1, 1'b1, {1'b1, 48'd0}, 3'd2, 1'b0);
    chk("exceed_1", 64'(exceed_cnt), 64'(32'd1));

    // Exact-quota boundary, zero-length packet, then drop on an empty entry.
    cfg_op(14'd7, {1'b0, 48'd500}, 1'b1);
    pkt_op(14'd7, 16'd500, 1'b1, 1'b1, {1'b0, 48'd0}, 3'd4, 1'b0);
    chk("ram7_zero", 64'(ram[7]), 64'(0));
    pkt_op(14'd7, 16'd0, 1'b1, 1'b1, {1'b0, 48'd0}, 3'd4, 1'b0);
    chk("exceed_still_1", 64'(exceed_cnt), 64'(32'd1));
    pkt_op(14'd7, 16'd1, 1'b1, 1'b1, {1'b0, 48'd0}, 3'd1, 1'b0);
    chk("exceed_2", 64'(exceed_cnt), 64'(32'd2));

    // Suppressed accesses: out-of-range id, counting disabled, out-of-range refill.
    pkt_op(14'd200, 16'd10, 1'b1, 1'b0, '0, 3'd4, 1'b1);
    pkt_op(14'd5, 16'd10, 1'b0, 1'b0, '0, 3'd4, 1'b0);
    cfg_op(14'd300, {1'b1, 48'd9}, 1'b0);
    chk("ram5_untouched", 64'(ram[5]), 64'({1'b1, 48'd0}));

    // Starvation limit: cfg must win after exactly four packet grants.
    pkt_vld = 1'b1; pkt_id = 14'd9; pkt_len = 16'd0; pkt_cnt_en = 1'b0;
    cfg_vld = 1'b1; cfg_id = 14'd9; cfg_wdata = {1'b0, 48'd77};
    grants = 0; seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      #1;
      if (cfg_rdy) begin
        seen = 1'b1;
        chk("starve_pkt_rdy", 64'(pkt_rdy), 64'(1'b0));
      end else begin
        if (pkt_rdy) grants++;
        @(negedge asclk);
      end
    end
    chk("starve_cfg_seen", 64'(seen), 64'(1'b1));
    chk("starve_grants", 64'(grants), 64'(4));
    @(negedge asclk); cfg_vld = 1'b0; pkt_vld = 1'b0; #1;
    chk("starve_cleared", 64'(dut.starve_cnt_q), 64'(0));
    chk("starve_cfg_wr", 64'(mem_en), 64'(1'b1));
    @(negedge asclk); #1;
    chk("ram9_refill", 64'(ram[9]), 64'({1'b0, 48'd77}));

    // Reset during PKT_RD: no result, INIT restarts at address 0.
    pkt_vld = 1'b1; pkt_id = 14'd5; pkt_len = 16'd1; pkt_cnt_en = 1'b1; #1;
    chk("abort_pkt_rdy", 64'(pkt_rdy), 64'(1'b1));
    @(negedge asclk); pkt_vld = 1'b0; #1;
    chk("abort_pkt_rd", 64'(mem_en), 64'(1'b1));
    aresetn = 1'b0; #1;
    chk("abort_mem_en", 64'(mem_en), 64'(1'b0));
    chk("abort_init_done", 64'(init_done), 64'(1'b0));
    chk("abort_exceed", 64'(exceed_cnt), 64'(32'd0));
    @(negedge asclk); aresetn = 1'b1; #1;
    chk("restart_en", 64'(mem_en & mem_we), 64'(1'b1));
    chk("restart_addr", 64'(mem_addr), 64'(14'd0));
    nres = 0;
    for (int c = 0; c < int'(NumId); c++) begin
      if (res_vld) nres++;
      @(negedge asclk); #1;
    end
    chk("abort_no_result", 64'(nres), 64'(0));
    chk("restart_done", 64'(init_done), 64'(1'b1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
